// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : registered, parametrised ALU for the multi-cycle MIPS datapath.
//
// Sits between the register-file read ports and the writeback mux. The
// controller issues an operation with start; the result and flags are
// registered and announced with a one-cycle done pulse. Single-cycle ops
// complete in the cycle after start. MUL (opcode 111) is an iterative
// shift-add multiplier that keeps busy high until its done cycle.
//
// Optional feature macro: ALU_SEQ_MUL_EN
//   defined   : opcode 111 runs the WIDTH-step iterative unsigned multiply.
//   undefined : no multiplier is built; opcode 111 completes in one cycle
//               with Output = 0, zero = 1 and all other flags 0.
//
// Parameters
//   WIDTH      operand/result width (>= 4)
//   SHW        shift-amount bits taken from BussB (derived from WIDTH)
// Ports
//   clk        clock, rising edge
//   reset      synchronous, active-high; abandons a multiply, clears outputs
//   start      request, sampled only while idle
//   ALUControl 000 ADD, 001 XOR, 010 SUB, 011 SLT, 100 AND, 101 OR,
//              110 SLL, 111 MUL
//   BussA      operand A
//   BussB      operand B
//   Output     registered result
//   CarryOut   registered carry (SUB: 1 = no borrow)
//   zero       registered, 1 when Output is all zeros (0 out of reset)
//   overflow   registered signed overflow (MUL: high half nonzero)
//   negative   registered true sign of the result
//   busy       high while a multiply is in progress
//   done       one-cycle pulse when Output and flags are updated
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] BussA,
    input  logic [WIDTH-1:0] BussB,
    output logic [WIDTH-1:0] Output,
    output logic             CarryOut,
    output logic             zero,
    output logic             overflow,
    output logic             negative,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_XOR = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic             sub_s;
    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH:0]   sum_s;
    logic             add_ovf_s;
    logic             add_sign_s;

    logic [WIDTH-1:0] alu_res_s;
    logic             alu_c_s;
    logic             alu_v_s;
    logic             alu_n_s;

    logic             upd_s;
    logic [WIDTH-1:0] res_s;
    logic             c_s;
    logic             v_s;
    logic             n_s;
    logic             busy_nxt_s;

    logic [WIDTH-1:0] out_r;
    logic             carry_r;
    logic             zero_r;
    logic             ovf_r;
    logic             neg_r;
    logic             busy_r;
    logic             done_r;

    // Shared adder: SUB and SLT use A + ~B + 1; true sign corrects for overflow
    always_comb begin
        sub_s = (ALUControl == OP_SUB) || (ALUControl == OP_SLT);
        if (sub_s) begin
            b_eff_s = ~BussB;
        end else begin
            b_eff_s = BussB;
        end
        sum_s      = {1'b0, BussA} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, sub_s};
        add_ovf_s  = (BussA[WIDTH-1] == b_eff_s[WIDTH-1]) &&
                     (sum_s[WIDTH-1] != BussA[WIDTH-1]);
        add_sign_s = sum_s[WIDTH-1] ^ add_ovf_s;
    end

    // Single-cycle operation decode; opcode 111 falls to all-zero results
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        alu_n_s   = 1'b0;
        case (ALUControl)
            OP_ADD, OP_SUB: begin
                alu_res_s = sum_s[WIDTH-1:0];
                alu_c_s   = sum_s[WIDTH];
                alu_v_s   = add_ovf_s;
                alu_n_s   = add_sign_s;
            end
            OP_XOR: begin
                alu_res_s = BussA ^ BussB;
                alu_n_s   = alu_res_s[WIDTH-1];
            end
            OP_SLT: begin
                alu_res_s = {{(WIDTH-1){1'b0}}, add_sign_s};
            end
            OP_AND: begin
                alu_res_s = BussA & BussB;
                alu_n_s   = alu_res_s[WIDTH-1];
            end
            OP_OR: begin
                alu_res_s = BussA | BussB;
                alu_n_s   = alu_res_s[WIDTH-1];
            end
            OP_SLL: begin
                alu_res_s = BussA << BussB[SHW-1:0];
                alu_n_s   = alu_res_s[WIDTH-1];
            end
            default: begin
                alu_res_s = {WIDTH{1'b0}};
            end
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_nxt_s;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [CW-1:0]      count_r;
    logic               mul_go_s;
    logic               mul_last_s;

    assign mul_go_s   = (state_r == ST_IDLE) && start && (ALUControl == OP_MUL);
    // The step that takes count from 1 to 0 is the last one and completes the op
    assign mul_last_s = (state_r == ST_MUL) && (count_r == CW'(1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mul_go_s) begin
                    state_nxt_s = ST_MUL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the multiplier LSB is set
    always_comb begin
        if (mplier_r[0]) begin
            acc_nxt_s = acc_r + mcand_r;
        end else begin
            acc_nxt_s = acc_r;
        end
    end

    // Multiplier datapath; operands are latched at start and used throughout
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (mul_go_s) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, BussA};
            mplier_r <= BussB;
            count_r  <= CW'(WIDTH);
        end else if (state_r == ST_MUL) begin
            acc_r    <= acc_nxt_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            count_r  <= count_r - CW'(1);
        end
    end

    // Output logic: what to register this cycle and whether done fires
    always_comb begin
        upd_s      = 1'b0;
        res_s      = alu_res_s;
        c_s        = alu_c_s;
        v_s        = alu_v_s;
        n_s        = alu_n_s;
        busy_nxt_s = (state_nxt_s == ST_MUL);
        case (state_r)
            ST_IDLE: begin
                if (start && (ALUControl != OP_MUL)) begin
                    upd_s = 1'b1;
                end else begin
                    upd_s = 1'b0;
                end
            end
            ST_MUL: begin
                if (mul_last_s) begin
                    upd_s = 1'b1;
                    res_s = acc_nxt_s[WIDTH-1:0];
                    c_s   = 1'b0;
                    v_s   = |acc_nxt_s[2*WIDTH-1:WIDTH];
                    n_s   = acc_nxt_s[WIDTH-1];
                end else begin
                    upd_s = 1'b0;
                end
            end
            default: begin
                upd_s = 1'b0;
            end
        endcase
    end
`else
    // Output logic: every accepted op completes in one cycle
    always_comb begin
        upd_s      = start;
        res_s      = alu_res_s;
        c_s        = alu_c_s;
        v_s        = alu_v_s;
        n_s        = alu_n_s;
        busy_nxt_s = 1'b0;
    end
`endif

    // Result and flag registers: load on completion, hold otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            out_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            zero_r  <= 1'b0;
            ovf_r   <= 1'b0;
            neg_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= upd_s;
            busy_r <= busy_nxt_s;
            if (upd_s) begin
                out_r   <= res_s;
                carry_r <= c_s;
                zero_r  <= (res_s == {WIDTH{1'b0}});
                ovf_r   <= v_s;
                neg_r   <= n_s;
            end
        end
    end

    assign Output   = out_r;
    assign CarryOut = carry_r;
    assign zero     = zero_r;
    assign overflow = ovf_r;
    assign negative = neg_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule
